// File: rtl/fetch_pkg.sv
// Shared constants for the PA-RISC instruction fetch front end.
package fetch_pkg;

  localparam int ADDR_W_DEFAULT = 8;
  localparam int INSTR_W        = 32;
  localparam int PC_STEP        = 4;

  localparam logic [INSTR_W-1:0]        NOP_INSTR        = 32'h0000_0000;
  localparam logic [ADDR_W_DEFAULT-1:0] RESET_PC_DEFAULT = 8'h00;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory bus between the fetch unit (master) and the combinational ROM (slave).
interface instruction_fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
);

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;

  modport master (output imem_addr, input  imem_data);
  modport slave  (input  imem_addr, output imem_data);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captured instruction, its address and a live bit.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [ADDR_W-1:0]  d_pc,
  input  logic               d_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               if_valid
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_instr <= NOP_INSTR;
      if_pc    <= '0;
      if_valid <= 1'b0;
    end else if (load) begin
      if_instr <= d_instr;
      if_pc    <= d_pc;
      if_valid <= d_valid;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC/nPC pair with one-delay-slot branching, feeding the IF/ID register.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  instruction_fetch_unit_if.master   imem,
  input  logic                       stall,
  input  logic                       branch_taken,
  input  logic [ADDR_W-1:0]          branch_target,
  input  logic                       nullify,
  output logic [ADDR_W-1:0]          pc,
  output logic [ADDR_W-1:0]          npc,
  output logic [INSTR_W-1:0]         if_instr,
  output logic [ADDR_W-1:0]          if_pc,
  output logic                       if_valid
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] npc_eff;

  assign imem.imem_addr = pc;

  // NOTE: combinational outputs get a default first so no path leaves them
  // unassigned and a latch cannot be inferred.
  always_comb begin
    npc_eff = npc;
    if (branch_taken) npc_eff = {branch_target[ADDR_W-1:2], 2'b00};
  end

  // The word at pc when a branch resolves is the delay slot; only the fetch
  // after it is redirected, so the target lands in pc rather than being fetched now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= RESET_PC;
      npc <= RESET_PC + STEP;
    end else if (!stall) begin
      pc  <= npc_eff;
      npc <= npc_eff + STEP;
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (~stall),
    .d_instr  (imem.imem_data),
    .d_pc     (pc),
    .d_valid  (~nullify),
    .if_instr (if_instr),
    .if_pc    (if_pc),
    .if_valid (if_valid)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed stimulus pushes expected
// IF/ID captures, a monitor pops and compares after every capturing edge.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    logic [7:0]  pc;
    logic        valid;
  } cap_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic        nullify = 1'b0;
  logic [7:0]  pc, npc, if_pc;
  logic [31:0] if_instr;
  logic        if_valid;

  int tests = 0;
  int fails = 0;
  cap_t exp_q[$];

  instruction_fetch_unit_if #(.ADDR_W(8)) imem_bus ();

  // ROM model: every word carries its own address so captures are self-identifying.
  function automatic logic [31:0] word_at(input logic [7:0] a);
    return {8'hC0, 8'h5E, 8'h00, a[7:2], 2'b00};
  endfunction

  assign imem_bus.imem_data = word_at(imem_bus.imem_addr);

  instruction_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (imem_bus),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .nullify       (nullify),
    .pc            (pc),
    .npc           (npc),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_valid      (if_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every edge with reset released and no stall is a capture.
  always @(posedge clk) begin
    if (rst_n && !stall) begin
      #1;
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        cap_t e;
        e = exp_q.pop_front();
        check("if_instr", if_instr, e.instr);
        check("if_pc",    {24'h0, if_pc}, {24'h0, e.pc});
        check("if_valid", {31'h0, if_valid}, {31'h0, e.valid});
      end
    end
  end

  // One cycle: drive inputs at negedge, queue the expected capture, then
  // check pc/npc at the following negedge.
  task automatic cyc(input logic st, input logic bt, input logic [7:0] tgt, input logic nul,
                     input logic [7:0] cap_pc, input logic cap_v,
                     input logic [7:0] exp_pc, input logic [7:0] exp_npc);
    stall = st; branch_taken = bt; branch_target = tgt; nullify = nul;
    if (!st) exp_q.push_back('{instr: word_at(cap_pc), pc: cap_pc, valid: cap_v});
    @(negedge clk);
    check("pc",  {24'h0, pc},  {24'h0, exp_pc});
    check("npc", {24'h0, npc}, {24'h0, exp_npc});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pc",       {24'h0, pc},  32'h00);
    check("rst_npc",      {24'h0, npc}, 32'h04);
    check("rst_if_instr", if_instr, 32'h0000_0000);
    check("rst_if_pc",    {24'h0, if_pc}, 32'h00);
    check("rst_if_valid", {31'h0, if_valid}, 32'h0);
    check("imem_addr",    {24'h0, imem_bus.imem_addr}, 32'h00);
    rst_n = 1'b1;

    // Sequential fetch, then stall with pc=8
    cyc(0, 0, 8'h00, 0, 8'h00, 1, 8'h04, 8'h08);
    cyc(0, 0, 8'h00, 0, 8'h04, 1, 8'h08, 8'h0C);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 8'h80, 1, 8'h00, 0, 8'h08, 8'h0C);
      check("stall_if_pc",    {24'h0, if_pc}, 32'h04);
      check("stall_if_instr", if_instr, word_at(8'h04));
      check("stall_if_valid", {31'h0, if_valid}, 32'h1);
    end
    cyc(0, 0, 8'h00, 0, 8'h08, 1, 8'h0C, 8'h10);
    cyc(0, 0, 8'h00, 0, 8'h0C, 1, 8'h10, 8'h14);

    // Branch at 0x10 to 0x41 (low bits masked), delay slot captured
    cyc(0, 1, 8'h41, 0, 8'h10, 1, 8'h40, 8'h44);
    cyc(0, 0, 8'h00, 0, 8'h40, 1, 8'h44, 8'h48);
    cyc(0, 1, 8'h10, 0, 8'h44, 1, 8'h10, 8'h14);

    // Branch plus nullified delay slot at 0x10
    cyc(0, 1, 8'h40, 1, 8'h10, 0, 8'h40, 8'h44);
    cyc(0, 0, 8'h00, 0, 8'h40, 1, 8'h44, 8'h48);

    // Wrap-around from 0xF8
    cyc(0, 1, 8'hFB, 0, 8'h44, 1, 8'hF8, 8'hFC);
    cyc(0, 0, 8'h00, 0, 8'hF8, 1, 8'hFC, 8'h00);
    cyc(0, 0, 8'h00, 0, 8'hFC, 1, 8'h00, 8'h04);
    cyc(0, 0, 8'h00, 0, 8'h00, 1, 8'h04, 8'h08);
    cyc(0, 0, 8'h00, 0, 8'h04, 1, 8'h08, 8'h0C);

    // Async reset mid-cycle during a stall with a pending branch
    stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h80;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pc",       {24'h0, pc},  32'h00);
    check("arst_npc",      {24'h0, npc}, 32'h04);
    check("arst_if_instr", if_instr, 32'h0000_0000);
    check("arst_if_pc",    {24'h0, if_pc}, 32'h00);
    check("arst_if_valid", {31'h0, if_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 8'h00, 0, 8'h00, 1, 8'h04, 8'h08);
    cyc(0, 0, 8'h00, 0, 8'h04, 1, 8'h08, 8'h0C);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

- Front end of the PA-RISC pipeline: owns the PC/nPC pair and drives the byte address of the combinational instruction ROM.
- Captures the returned 32-bit big-endian word into the IF/ID register together with its PC and a valid bit.
- Implements sequential fetch, stall hold, redirect to a branch target after one delay slot, and delay-slot nullification.

## Interface
Parameters:
- ADDR_W, 8, instruction address width (256-byte ROM space)
- RESET_PC, 8'h00, address of the first instruction fetched after reset

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  out  ADDR_W  byte address to ROM; equals pc
- imem_data  in  32  instruction word returned combinationally by ROM for imem_addr
- stall  in  1  hazard unit request to hold IF and IF/ID
- branch_taken  in  1  ID stage resolved a taken branch this cycle
- branch_target  in  ADDR_W  target address; bits [1:0] ignored (treated as 00)
- nullify  in  1  squash the instruction being captured into IF/ID this cycle (delay-slot nullification)
- pc  out  ADDR_W  current fetch address
- npc  out  ADDR_W  next fetch address (used by ID for link values)
- if_instr  out  32  IF/ID instruction register
- if_pc  out  ADDR_W  address of if_instr
- if_valid  out  1  if_instr is a live instruction

## Operation
- While rst_n low: pc=RESET_PC, npc=RESET_PC+4, if_instr=32'h0000_0000 (NOP), if_pc=0, if_valid=0, all asynchronously.
- imem_addr = pc at all times (pure wire, no register).
- Effective next address: npc_eff = branch_taken ? {branch_target[ADDR_W-1:2],2'b00} : npc.
- Advance (stall=0) on each rising edge:
  - if_instr <= imem_data and if_pc <= pc.
  - if_valid <= ~nullify.
  - pc <= npc_eff and npc <= npc_eff+4.
- Stall (stall=1): pc, npc, if_instr, if_pc, if_valid all hold. branch_taken and nullify are ignored; ID presents them again when the stall drops.
- Priority: rst_n > stall > branch_taken/nullify. branch_taken and nullify may be asserted together; both take effect.
- Delayed branch semantics: the word at pc when branch_taken is sampled is the delay slot. It is captured (valid unless nullify) and the following fetch is the target.
- Arithmetic: all address adds are ADDR_W-bit modulo. 8'hFC+4 wraps to 8'h00 with no flag.
- pc is always word-aligned; RESET_PC must have bits [1:0]=00.
- When nullify=1, if_instr is still loaded with the real word; only if_valid clears.

## Timing
- Fetch latency: one cycle. A word at address X with pc==X and stall=0 appears on if_instr after the next rising edge.
- Branch penalty: zero bubbles. The delay slot is fetched in the cycle branch_taken is sampled, and the target is on pc one edge later.
- Reset release mid-operation: the first edge with rst_n high captures Mem[RESET_PC..+3] and sets if_valid=1. Any pending redirect is lost.
- Stall asserted N cycles: outputs are frozen for exactly N edges, and fetch resumes with no skipped or duplicated address.

## Structure
- Shared package `fetch_pkg`:
  - ADDR_W default
  - INSTR_W=32
  - PC_STEP=4
  - NOP_INSTR=32'h0000_0000
  - RESET_PC default
- Sub-module `if_id_reg`: holds if_instr/if_pc/if_valid with load-enable (~stall) and async reset.
- PC/nPC update logic stays in the top.

## Test plan
- Reset then 4 free-running cycles with ROM words W0..W3 at 0,4,8,C: if_pc = 0,4,8,C in order, if_instr = W0..W3, and if_valid=1 from the first edge after release.
- stall=1 for 3 cycles while pc=8: pc, npc, if_instr and if_pc are frozen for those 3 edges. After release, if_pc = 8 then C with no gap.
- branch_taken=1, branch_target=8'h41 while pc=8'h10: the next capture is the delay slot at 8'h10, then pc=8'h40 and npc=8'h44. The low bits of the target are masked.
- branch_taken=1 with nullify=1 at pc=8'h10: if_pc=8'h10 with if_valid=0, and the next cycle if_pc=8'h40 with if_valid=1.
- Free-run from pc=8'hF8: pc sequence F8, FC, 00, 04, and npc wraps correctly.
- rst_n pulsed low asynchronously mid-cycle during a stall with a pending branch: outputs go to reset values immediately, and fetch restarts at RESET_PC.
